// File: rtl/mux81_pkg.sv
// Shared types, sizes and the rotating priority search for the mux81 scheduler.
package mux81_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Rotate req so that index p lands at bit 0, take the lowest set bit, then
  // rotate the found offset back to an absolute requester index.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r,
                                    input logic [SEL_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    pick_t              res;
    dbl = {r, r};
    rot = dbl[p +: N_REQ];
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    res.found = |rot;
    res.idx   = off + p;
    return res;
  endfunction

endpackage

// File: rtl/mux81_rr_sched_if.sv
// Requester-side bundle of the scheduler: requests, data bits, grant and muxed output.
interface mux81_rr_sched_if;
  import mux81_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             dout;

  modport master (output en, req, din, input gnt, sel, busy, dout);
  modport slave  (input en, req, din, output gnt, sel, busy, dout);
endinterface

// File: rtl/mux81_rr_sched_mux81.sv
// Plain 8:1 bit multiplexer; inputs a..h selected by {s2,s1,s0}.
module mux81
  import mux81_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic o
);

  logic [N_REQ-1:0] in_vec;
  logic [SEL_W-1:0] sel_vec;
  logic [N_REQ-1:0] hit;

  assign in_vec  = {h, g, f, e, d, c, b, a};
  assign sel_vec = {s2, s1, s0};

  // AND-OR form: each input is qualified by its own decoded select.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_leg
    assign hit[gi] = in_vec[gi] & (sel_vec == SEL_W'(gi));
  end

  assign o = |hit;

endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin owner of a shared mux81: one-hot grant, registered select, capped tenure.
module mux81_rr_sched
  import mux81_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux81_rr_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg,   gnt_next;
  logic [SEL_W-1:0] sel_reg,   sel_next;
  logic             busy_reg,  busy_next;
  logic [CNT_W-1:0] hold_reg,  hold_next;
  logic [SEL_W-1:0] ptr_reg,   ptr_next;
  pick_t            pick;
  logic             do_grant;
  logic             release_now;
  logic             mux_o;

  // State and grant registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
      hold_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      hold_reg  <= hold_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Next-state: grant from idle, hold/extend a tenure, or hand over with no bubble.
  // The search starts at owner+1, so an expiring owner is only re-picked when alone.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    sel_next    = sel_reg;
    busy_next   = busy_reg;
    hold_next   = hold_reg;
    ptr_next    = ptr_reg;
    do_grant    = 1'b0;
    release_now = 1'b0;
    pick        = rr_pick(bus.req, ptr_reg);

    case (state_reg)
      IDLE: begin
        do_grant = bus.en && pick.found;
      end
      GRANT: begin
        release_now = !bus.req[sel_reg] || (hold_reg == HOLD_LAST);
        if (release_now) begin
          if (bus.en && pick.found) begin
            do_grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
            hold_next  = '0;
          end
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (do_grant) begin
      state_next = GRANT;
      gnt_next   = N_REQ'(1) << pick.idx;
      sel_next   = pick.idx;
      busy_next  = 1'b1;
      hold_next  = '0;
      ptr_next   = pick.idx + 1'b1;
    end
  end

  mux81 u_mux81 (
    .a  (bus.din[0]),
    .b  (bus.din[1]),
    .c  (bus.din[2]),
    .d  (bus.din[3]),
    .e  (bus.din[4]),
    .f  (bus.din[5]),
    .g  (bus.din[6]),
    .h  (bus.din[7]),
    .s0 (sel_reg[0]),
    .s1 (sel_reg[1]),
    .s2 (sel_reg[2]),
    .o  (mux_o)
  );

  assign bus.gnt  = gnt_reg;
  assign bus.sel  = sel_reg;
  assign bus.busy = busy_reg;
  assign bus.dout = busy_reg & mux_o;

endmodule
